// File: rtl/iter_divider_if.sv
// Request/response bundle for the iterative divider.
// A transfer occurs on a rising aclk edge where valid && ready; the sender holds valid and its payload until then, and ready never depends on valid.
interface iter_divider_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output in_valid, op, dividend, divisor, in_tag, flush, out_ready,
    input  in_ready, out_valid, result, out_tag, busy
  );

  modport slave (
    input  in_valid, op, dividend, divisor, in_tag, flush, out_ready,
    output in_ready, out_valid, result, out_tag, busy
  );
endinterface

// File: rtl/iter_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle, DIV/MOD/DIVU/MODU.
// Signed ops divide magnitudes and apply a truncating sign fix-up on the last step.
module iter_divider #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic          aclk,
  input  logic          areset,
  iter_divider_if.slave bus,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             op_mod;
  logic             neg_quo;
  logic             neg_rem;
  logic [WIDTH-1:0] result_q;
  logic [TAG_W-1:0] tag_q;

  logic             accept;
  logic             is_signed;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   trial;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign bus.in_ready  = (state == S_IDLE) && !bus.flush;
  assign bus.out_valid = (state == S_DONE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.result    = result_q;
  assign bus.out_tag   = tag_q;
  assign dbg_state     = state;

  assign accept    = bus.in_valid && bus.in_ready;
  assign is_signed = !bus.op[1];
  assign dvd_neg   = is_signed && bus.dividend[WIDTH-1];
  assign dvs_neg   = is_signed && bus.divisor[WIDTH-1];
  // The most-negative value maps onto itself, which is its correct unsigned magnitude.
  assign dvd_mag   = dvd_neg ? -bus.dividend : bus.dividend;
  assign dvs_mag   = dvs_neg ? -bus.divisor  : bus.divisor;

  // quo_q starts as the dividend magnitude; its MSB feeds the partial remainder while quotient bits shift in at the bottom.
  assign trial     = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
  assign no_borrow = !trial[WIDTH];
  assign rem_nxt   = no_borrow ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
  assign quo_nxt   = {quo_q[WIDTH-2:0], no_borrow};
  assign quo_fix   = neg_quo ? -quo_nxt : quo_nxt;
  assign rem_fix   = neg_rem ? -rem_nxt : rem_nxt;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      op_mod   <= 1'b0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      result_q <= '0;
      tag_q    <= '0;
    end else if (bus.flush) begin
      // Also covers flush together with out_ready in DONE: both end in IDLE.
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            tag_q   <= bus.in_tag;
            op_mod  <= bus.op[0];
            neg_quo <= dvd_neg ^ dvs_neg;
            neg_rem <= dvd_neg;
            dvs_q   <= dvs_mag;
            quo_q   <= dvd_mag;
            rem_q   <= '0;
            if (bus.divisor == '0) begin
              result_q <= bus.op[0] ? bus.dividend : '1;
              state    <= S_DONE;
            end else begin
              cnt   <= CNT_W'(WIDTH);
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt   <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            result_q <= op_mod ? rem_fix : quo_fix;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Randomized scoreboard bench for iter_divider, with directed corner cases,
// flush and reset scenarios.
module tb_iter_divider;
  localparam int WIDTH = 32;
  localparam int TAG_W = 5;

  logic       aclk = 1'b0;
  logic       areset;
  logic [1:0] dbg_state;

  iter_divider_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  iter_divider #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;
  logic [TAG_W+WIDTH-1:0] exp_q[$];
  logic [TAG_W+WIDTH-1:0] mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain 64-bit arithmetic, SV division truncates toward zero.
  function automatic logic [WIDTH-1:0] ref_div(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    longint sa, sb, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {{(64-WIDTH){1'b0}}, a};
    ub = {{(64-WIDTH){1'b0}}, b};
    if (b == '0) return op[0] ? a : '1;
    case (op)
      2'd0:    r = sa / sb;
      2'd1:    r = sa % sb;
      2'd2:    r = longint'(ua / ub);
      default: r = longint'(ua % ub);
    endcase
    return r[WIDTH-1:0];
  endfunction

  // monitor: a handshake completes on the next rising edge
  always @(negedge aclk) begin
    if (!areset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got tag %0d result %0h, want no result", bus.out_tag, bus.result);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", bus.result, mon_e[WIDTH-1:0]);
        check("out_tag", bus.out_tag, mon_e[TAG_W+WIDTH-1:WIDTH]);
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      step();
      n++;
    end
    check("in_ready_wait", bus.in_ready, 1);
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_tag   = tag;
    step();
    bus.in_valid = 1'b0;
  endtask

  // Issue one op, check latency in edges after the acceptance edge, hold out_ready low for `hold` cycles.
  task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [TAG_W-1:0] tag, input int hold, input logic [WIDTH-1:0] exp_res);
    int lat;
    wait_ready();
    exp_q.push_back({tag, exp_res});
    drive_req(op, a, b, tag);
    lat = 0;
    while (!bus.out_valid && lat < WIDTH + 10) begin
      step();
      lat++;
    end
    check("latency", lat, (b == '0) ? 0 : WIDTH);
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", bus.out_valid, 1);
      check("hold_result", bus.result, exp_res);
      check("hold_tag", bus.out_tag, tag);
      check("hold_in_ready", bus.in_ready, 0);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("busy_after", bus.busy, 0);
  endtask

  task automatic watch_silent(input string name, input int cycles);
    int seen = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      if (bus.out_valid) seen++;
      step();
    end
    bus.out_ready = 1'b0;
    check(name, seen, 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_out_valid"}, bus.out_valid, 0);
    check({name, "_busy"}, bus.busy, 0);
    check({name, "_result"}, bus.result, 0);
    check({name, "_out_tag"}, bus.out_tag, 0);
    check({name, "_in_ready"}, bus.in_ready, 1);
    check({name, "_state"}, dbg_state, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a, r_b;
    areset        = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = 2'd0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.in_tag    = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    #3;
    check_reset_outputs("por");
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;
    step();

    // directed values
    issue(2'd0, 32'd100, 32'd7, 5'd3, 0, 32'd14);
    issue(2'd1, 32'd100, 32'd7, 5'd3, 0, 32'd2);
    issue(2'd1, 32'hFFFFFFF9, 32'd2, 5'd1, 0, 32'hFFFFFFFF);
    issue(2'd0, 32'hFFFFFFF9, 32'd2, 5'd2, 5, 32'hFFFFFFFD);
    issue(2'd2, 32'hFFFFFFFF, 32'd2, 5'd4, 0, 32'h7FFFFFFF);
    issue(2'd3, 32'hFFFFFFFF, 32'd2, 5'd5, 0, 32'd1);
    issue(2'd0, 32'h80000000, 32'hFFFFFFFF, 5'd6, 0, 32'h80000000);
    issue(2'd1, 32'h80000000, 32'hFFFFFFFF, 5'd7, 0, 32'd0);
    issue(2'd2, 32'd5, 32'd0, 5'd8, 0, 32'hFFFFFFFF);
    issue(2'd1, 32'd5, 32'd0, 5'd9, 3, 32'd5);
    issue(2'd0, 32'hFFFFFFF3, 32'd0, 5'd10, 0, 32'hFFFFFFFF);
    issue(2'd3, 32'hFFFFFFF3, 32'd0, 5'd11, 0, 32'hFFFFFFF3);
    issue(2'd0, 32'h7FFFFFFF, 32'h80000000, 5'd31, 0, 32'd0);

    // flush 10 cycles into CALC
    wait_ready();
    drive_req(2'd0, 32'd1000, 32'd3, 5'd12);
    repeat (9) step();
    check("calc_busy", bus.busy, 1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush_busy", bus.busy, 0);
    check("flush_out_valid", bus.out_valid, 0);
    watch_silent("flush_no_result", 40);
    issue(2'd0, 32'd1000, 32'd3, 5'd12, 0, 32'd333);

    // flush with in_valid in IDLE: not accepted
    wait_ready();
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.op       = 2'd2;
    bus.dividend = 32'd9;
    bus.divisor  = 32'd0;
    bus.in_tag   = 5'd13;
    #1;
    check("flush_in_ready", bus.in_ready, 0);
    @(posedge aclk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_idle_busy", bus.busy, 0);
    watch_silent("flush_idle_no_result", 5);

    // flush with out_ready in DONE still delivers
    wait_ready();
    exp_q.push_back({5'd14, 32'hFFFFFFFF});
    drive_req(2'd2, 32'd5, 32'd0, 5'd14);
    check("done_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    step();
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    check("flush_done_busy", bus.busy, 0);

    // async reset mid-CALC
    wait_ready();
    drive_req(2'd0, 32'd100, 32'd7, 5'd15);
    repeat (5) step();
    #2;
    areset = 1'b1;
    #1;
    check_reset_outputs("calc_rst");
    @(posedge aclk);
    #1;
    areset = 1'b0;
    watch_silent("calc_rst_no_result", 40);

    // async reset in DONE
    wait_ready();
    drive_req(2'd3, 32'd77, 32'd0, 5'd16);
    check("done_rst_pre", bus.out_valid, 1);
    #3;
    areset = 1'b1;
    #1;
    check_reset_outputs("done_rst");
    @(posedge aclk);
    #1;
    areset = 1'b0;
    watch_silent("done_rst_no_result", 10);

    // random stimulus against the reference model
    for (int k = 0; k < 60; k++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      if ($urandom_range(0, 7) == 0) r_a = 32'h80000000;
      case ($urandom_range(0, 5))
        0:       r_b = '0;
        1:       r_b = 32'($urandom_range(1, 15));
        2:       r_b = '1;
        3:       r_b = -32'($urandom_range(1, 15));
        default: r_b = $urandom;
      endcase
      issue(r_op, r_a, r_b, 5'($urandom_range(0, 31)), $urandom_range(0, 3), ref_div(r_op, r_a, r_b));
    end

    step();
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
